// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared widths, default scan divider and anode constants for the
// multiplexed 4-digit display scanner.
package seg_scan_pkg;
    localparam int DIGITS      = 4;
    localparam int NIBBLE      = 4;
    localparam int DIV_DEFAULT = 50000;
    localparam logic [DIGITS-1:0] AN_OFF = 4'b1111;
    localparam logic [DIGITS-1:0] AN_D0  = 4'b1110;
    typedef logic [NIBBLE-1:0] nibble_t;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler counting 0..DIV-1; tick is high in the
// terminal-count cycle.
module tick_gen
    import seg_scan_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk)
        if (rst) r_cnt <= '0;
        else     r_cnt <= tick ? '0 : r_cnt + 1'b1;
    assign tick = r_cnt == LAST;
endmodule

// File: rtl/seg_scan.sv
// seg_scan: scans four hex digits onto a shared nibble bus with active-low
// anodes, double-buffered loads committed at frame boundaries, and zero blanking.
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [DIGITS*NIBBLE-1:0] din,
    input  logic                     lz_en,
    output nibble_t                  b,
    output logic [DIGITS-1:0]        an,
    output logic                     blank,
    output logic                     frame,
    output logic                     pend
);
    logic [1:0]               r_idx;
    logic [DIGITS*NIBBLE-1:0] r_disp;
    logic [DIGITS*NIBBLE-1:0] r_shadow;
    logic                     r_pend;
    logic                     w_tick;
    logic                     w_wrap;
    logic                     w_blank;
    logic [DIGITS*NIBBLE-1:0] w_rest;

    tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_wrap = w_tick && r_idx == 2'd3;

    // A load coinciding with the wrap bypasses the shadow and goes straight to disp.
    always_ff @(posedge clk)
        if (rst) begin
            r_idx    <= '0;
            r_disp   <= '0;
            r_shadow <= '0;
            r_pend   <= 1'b0;
        end else begin
            if (w_tick) r_idx <= r_idx + 2'd1;
            if (load && w_wrap) begin
                r_disp <= din;
                r_pend <= 1'b0;
            end else if (load) begin
                r_shadow <= din;
                r_pend   <= 1'b1;
            end else if (w_wrap && r_pend) begin
                r_disp <= r_shadow;
                r_pend <= 1'b0;
            end
        end

    // Nibbles from the current digit upward; all-zero means a leading zero.
    assign w_rest  = r_disp >> {r_idx, 2'b00};
    assign w_blank = lz_en && r_idx != 2'd0 && w_rest == '0;

    always_comb begin
        blank = w_blank;
        b     = w_blank ? '0 : w_rest[NIBBLE-1:0];
        an    = w_blank ? AN_OFF : ~(DIGITS'(1) << r_idx);
        frame = w_wrap;
        pend  = r_pend;
    end
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed scenarios plus a randomized run, all checked against a
// frame-position reference model of the scanner.
module tb_seg_scan;
    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] din = '0;
    logic        lz_en = 1'b0;
    logic [3:0]  b;
    logic [3:0]  an;
    logic        blank;
    logic        frame;
    logic        pend;

    int n_chk  = 0;
    int n_pass = 0;

    seg_scan #(.DIV(DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .din   (din),
        .lz_en (lz_en),
        .b     (b),
        .an    (an),
        .blank (blank),
        .frame (frame),
        .pend  (pend)
    );

    always #5 clk = ~clk;

    // Reference model: position within the frame plus the three storage values.
    int          m_t;
    logic [15:0] m_disp;
    logic [15:0] m_shadow;
    logic        m_pend;

    always @(posedge clk)
        if (rst) begin
            m_t      <= 0;
            m_disp   <= '0;
            m_shadow <= '0;
            m_pend   <= 1'b0;
        end else begin
            m_t <= (m_t + 1) % FRAME;
            if (load && m_t == FRAME - 1) begin
                m_disp <= din;
                m_pend <= 1'b0;
            end else if (load) begin
                m_shadow <= din;
                m_pend   <= 1'b1;
            end else if (m_t == FRAME - 1 && m_pend) begin
                m_disp <= m_shadow;
                m_pend <= 1'b0;
            end
        end

    function automatic logic ex_blank(int d, logic [15:0] v, logic lz);
        if (d == 0 || !lz) return 1'b0;
        for (int k = d; k < 4; k++)
            if (v[4*k +: 4] != 4'h0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] ex_an(int d, logic [15:0] v, logic lz);
        logic [3:0] one;
        one = 4'b0001;
        return ex_blank(d, v, lz) ? 4'b1111 : ~(one << d);
    endfunction

    function automatic logic [3:0] ex_b(int d, logic [15:0] v, logic lz);
        return ex_blank(d, v, lz) ? 4'h0 : v[4*d +: 4];
    endfunction

    task automatic test_reset;
        int k;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_chk++; if (an !== 4'b1110) $display("FAIL reset_an got %b want 1110", an); else n_pass++;
        n_chk++; if (b !== 4'h0) $display("FAIL reset_b got %h want 0", b); else n_pass++;
        n_chk++; if (blank !== 1'b0) $display("FAIL reset_blank got %b want 0", blank); else n_pass++;
        n_chk++; if (frame !== 1'b0) $display("FAIL reset_frame got %b want 0", frame); else n_pass++;
        n_chk++; if (pend !== 1'b0) $display("FAIL reset_pend got %b want 0", pend); else n_pass++;
        k = 0;
        while (an === 4'b1110 && k < 10) begin
            @(negedge clk);
            k++;
        end
        n_chk++; if (k != 4) $display("FAIL first_tick got %0d cycles want 4", k); else n_pass++;
        n_chk++; if (an !== 4'b1101) $display("FAIL first_tick_an got %b want 1101", an); else n_pass++;
    endtask

    // Leaves the bench at the negedge where frame is high (bounded wait).
    task automatic align_frame(input string tag);
        int k;
        k = 0;
        while (frame !== 1'b1 && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        n_chk++; if (frame !== 1'b1) $display("FAIL %s_frame_timeout got %b want 1", tag, frame); else n_pass++;
    endtask

    task automatic test_load_1234;
        logic [15:0] v;
        int k;
        v = 16'h1234;
        lz_en = 1'b0;
        align_frame("l1234_align");
        @(negedge clk);
        load = 1'b1;
        din  = v;
        @(negedge clk);
        load = 1'b0;
        k = 0;
        while (frame !== 1'b1 && k < 2 * FRAME) begin
            n_chk++; if (pend !== 1'b1) $display("FAIL l1234_pend got %b want 1", pend); else n_pass++;
            @(negedge clk);
            k++;
        end
        n_chk++; if (frame !== 1'b1) $display("FAIL l1234_wrap_timeout got %b want 1", frame); else n_pass++;
        n_chk++; if (pend !== 1'b1) $display("FAIL l1234_pend_at_wrap got %b want 1", pend); else n_pass++;
        for (int j = 0; j < FRAME; j++) begin
            @(negedge clk);
            n_chk++; if (an !== ex_an(j / DIV, v, 1'b0)) $display("FAIL l1234_an[%0d] got %b want %b", j, an, ex_an(j / DIV, v, 1'b0)); else n_pass++;
            n_chk++; if (b !== v[4*(j/DIV) +: 4]) $display("FAIL l1234_b[%0d] got %h want %h", j, b, v[4*(j/DIV) +: 4]); else n_pass++;
            n_chk++; if (pend !== 1'b0) $display("FAIL l1234_pend_after[%0d] got %b want 0", j, pend); else n_pass++;
        end
    endtask

    task automatic test_lz(input logic [15:0] v, input string tag);
        int k;
        lz_en = 1'b1;
        @(negedge clk);
        load = 1'b1;
        din  = v;
        @(negedge clk);
        load = 1'b0;
        k = 0;
        while (frame !== 1'b1 && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        n_chk++; if (frame !== 1'b1) $display("FAIL %s_wrap_timeout got %b want 1", tag, frame); else n_pass++;
        for (int j = 0; j < FRAME; j++) begin
            @(negedge clk);
            n_chk++; if (an !== ex_an(j / DIV, v, 1'b1)) $display("FAIL %s_an[%0d] got %b want %b", tag, j, an, ex_an(j / DIV, v, 1'b1)); else n_pass++;
            n_chk++; if (b !== ex_b(j / DIV, v, 1'b1)) $display("FAIL %s_b[%0d] got %h want %h", tag, j, b, ex_b(j / DIV, v, 1'b1)); else n_pass++;
            n_chk++; if (blank !== ex_blank(j / DIV, v, 1'b1)) $display("FAIL %s_blank[%0d] got %b want %b", tag, j, blank, ex_blank(j / DIV, v, 1'b1)); else n_pass++;
        end
    endtask

    task automatic test_last_wins;
        int k;
        lz_en = 1'b0;
        @(negedge clk);
        load = 1'b1;
        din  = 16'hAAAA;
        @(negedge clk);
        din  = 16'hBBBB;
        @(negedge clk);
        load = 1'b0;
        k = 0;
        while (frame !== 1'b1 && k < 2 * FRAME) begin
            n_chk++; if (b === 4'hA) $display("FAIL lw_early_b got %h want not A", b); else n_pass++;
            @(negedge clk);
            k++;
        end
        n_chk++; if (frame !== 1'b1) $display("FAIL lw_wrap_timeout got %b want 1", frame); else n_pass++;
        for (int j = 0; j < FRAME; j++) begin
            @(negedge clk);
            n_chk++; if (b !== 4'hB) $display("FAIL lw_b[%0d] got %h want B", j, b); else n_pass++;
        end
    endtask

    // Entered at the negedge where frame is high, so this load hits the wrap tick.
    task automatic test_wrap_load;
        n_chk++; if (frame !== 1'b1) $display("FAIL wl_setup_frame got %b want 1", frame); else n_pass++;
        load = 1'b1;
        din  = 16'h5678;
        @(negedge clk);
        load = 1'b0;
        n_chk++; if (pend !== 1'b0) $display("FAIL wl_pend got %b want 0", pend); else n_pass++;
        n_chk++; if (an !== 4'b1110) $display("FAIL wl_an got %b want 1110", an); else n_pass++;
        n_chk++; if (b !== 4'h8) $display("FAIL wl_b got %h want 8", b); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int k;
        lz_en = 1'b0;
        @(negedge clk);
        load = 1'b1;
        din  = 16'h9999;
        @(negedge clk);
        load = 1'b0;
        k = 0;
        while (an !== 4'b1011 && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        n_chk++; if (an !== 4'b1011) $display("FAIL rm_idx2_timeout got %b want 1011", an); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_chk++; if (an !== 4'b1110) $display("FAIL rm_an got %b want 1110", an); else n_pass++;
        n_chk++; if (b !== 4'h0) $display("FAIL rm_b got %h want 0", b); else n_pass++;
        n_chk++; if (pend !== 1'b0) $display("FAIL rm_pend got %b want 0", pend); else n_pass++;
        for (int j = 0; j < FRAME + DIV; j++) begin
            @(negedge clk);
            n_chk++; if (b !== 4'h0) $display("FAIL rm_discard_b[%0d] got %h want 0", j, b); else n_pass++;
        end
    endtask

    task automatic test_random;
        for (int j = 0; j < 800; j++) begin
            @(negedge clk);
            if (!rst) begin
                n_chk++; if (an !== ex_an(m_t / DIV, m_disp, lz_en)) $display("FAIL rnd_an[%0d] got %b want %b", j, an, ex_an(m_t / DIV, m_disp, lz_en)); else n_pass++;
                n_chk++; if (b !== ex_b(m_t / DIV, m_disp, lz_en)) $display("FAIL rnd_b[%0d] got %h want %h", j, b, ex_b(m_t / DIV, m_disp, lz_en)); else n_pass++;
                n_chk++; if (blank !== ex_blank(m_t / DIV, m_disp, lz_en)) $display("FAIL rnd_blank[%0d] got %b want %b", j, blank, ex_blank(m_t / DIV, m_disp, lz_en)); else n_pass++;
                n_chk++; if (frame !== (m_t == FRAME - 1)) $display("FAIL rnd_frame[%0d] got %b want %b", j, frame, m_t == FRAME - 1); else n_pass++;
                n_chk++; if (pend !== m_pend) $display("FAIL rnd_pend[%0d] got %b want %b", j, pend, m_pend); else n_pass++;
            end
            rst   = ($urandom_range(0, 99) == 0);
            load  = ($urandom_range(0, 9) == 0);
            lz_en = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       din = 16'h0000;
                1:       din = 16'($urandom_range(0, 255));
                2:       din = 16'($urandom_range(0, 15)) << 12;
                default: din = 16'($urandom);
            endcase
        end
        rst  = 1'b0;
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_1234();
        test_lz(16'h0050, "lz0050");
        test_lz(16'h0000, "lz0000");
        test_last_wins();
        test_wrap_load();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
